shift_register_ctrl: RTL and testbench

Two-port round-robin controller that shares one `shift_register` instance between requesters A and B. A requester hands over a WIDTH-bit word and a direction. The controller then serially loads the word into the shift register over WIDTH enabled cycles, reads the register back, and reports completion with a match flag. It sits directly in front of the shift register and drives its `en`, `dir` and `data_in` pins.

---
 rtl/shift_register_ctrl.sv | 110 +++++++++++
 tb/tb_shift_register_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
// Round-robin front end that lets requesters A and B share one serial shift register:
// loads a granted word bit by bit, reads the register back and reports a match flag.
module shift_register_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_dir,
  input  logic [WIDTH-1:0] a_word,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_dir,
  input  logic [WIDTH-1:0] b_word,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_data_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             done_ok
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] word_p0;
  logic             dir_p0;
  logic             id_p0;
  logic             prio_b;
  logic             done_p1, done_id_p1, done_ok_p1;
  logic             grant_a, grant_b, take;

  // Arbitration and next state; a tie goes to whoever was not served last
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        grant_a = a_valid && (!b_valid || !prio_b);
        grant_b = b_valid && (!a_valid || prio_b);
        if (grant_a || grant_b) state_nxt = SHIFT;
      end
      SHIFT:   if (cnt == LAST) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign take    = grant_a || grant_b;
  assign a_ready = nrst && grant_a;
  assign b_ready = nrst && grant_b;

  // Stage p0: capture request on handshake, step the bit counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_p0 <= 1'b0;
      id_p0  <= 1'b0;
      prio_b <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        cnt    <= '0;
        dir_p0 <= grant_b ? b_dir : a_dir;
        id_p0  <= grant_b;
        prio_b <= !grant_b;
      end else if (state == SHIFT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) word_p0 <= grant_b ? b_word : a_word;
  end

  // Stage p1: readback compare registered into the completion pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_p1    <= 1'b0;
      done_id_p1 <= 1'b0;
      done_ok_p1 <= 1'b0;
    end else begin
      done_p1    <= (state == CHECK);
      done_ok_p1 <= (state == CHECK) && (sr_q == word_p0);
      if (state == CHECK) done_id_p1 <= id_p0;
    end
  end

  // Right shifts feed LSB first, left shifts MSB first, so the word lands in place
  assign idx        = dir_p0 ? cnt : LAST - cnt;
  assign sr_en      = (state == SHIFT);
  assign sr_dir     = dir_p0;
  assign sr_data_in = (state == SHIFT) && word_p0[idx];
  assign busy       = (state != IDLE);
  assign done       = done_p1;
  assign done_id    = done_id_p1;
  assign done_ok    = done_ok_p1;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench for shift_register_ctrl with a behavioural shift register model
// and a scoreboard of expected completions.
module tb_shift_register_ctrl;
  localparam int W = 5;

  logic         clk, nrst;
  logic         a_valid, a_ready, a_dir;
  logic [W-1:0] a_word;
  logic         b_valid, b_ready, b_dir;
  logic [W-1:0] b_word;
  logic         sr_en, sr_dir, sr_data_in;
  logic [W-1:0] sr_q, sreg;
  logic         busy, done, done_id, done_ok;
  logic         corrupt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic id; logic ok;} exp_t;
  exp_t sb[$];

  shift_register_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .nrst(nrst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_word(a_word),
    .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_word(b_word),
    .sr_en(sr_en), .sr_dir(sr_dir), .sr_data_in(sr_data_in), .sr_q(sr_q),
    .busy(busy), .done(done), .done_id(done_id), .done_ok(done_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached shift register: dir=1 enters at MSB, dir=0 enters at LSB
  always @(posedge clk or negedge nrst) begin
    if (!nrst) sreg <= '0;
    else if (sr_en) sreg <= sr_dir ? {sr_data_in, sreg[W-1:1]} : {sreg[W-2:0], sr_data_in};
  end
  assign sr_q = sreg ^ {{(W-1){1'b0}}, corrupt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 (inputs driven, #1 elapsed); returns in cycle W+2 after done
  task automatic run_xfer(input logic id, input logic dir, input logic [W-1:0] w,
                          input logic bad_q, input logic drop, input logic late_b);
    exp_t e;
    chk("ready_grant", id ? b_ready : a_ready, 1);
    chk("ready_other", id ? a_ready : b_ready, 0);
    e.id = id;
    e.ok = !bad_q;
    sb.push_back(e);
    corrupt = bad_q;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 1 && drop) begin
        if (id) b_valid = 1'b0;
        else    a_valid = 1'b0;
      end
      if (c == 2 && late_b) begin
        b_valid = 1'b1; b_dir = 1'b0; b_word = 5'b10011;
      end
      #1;
      if (c <= W) begin
        chk("shift_en", sr_en, 1);
        chk("shift_dir", sr_dir, dir);
        chk("shift_data", sr_data_in, dir ? w[c-1] : w[W-c]);
        chk("shift_busy", busy, 1);
        chk("shift_done", done, 0);
        chk("shift_ready", {a_ready, b_ready}, 0);
      end else if (c == W + 1) begin
        chk("check_en", sr_en, 0);
        chk("check_data", sr_data_in, 0);
        chk("check_busy", busy, 1);
        chk("check_sreg", sr_q, w ^ {{(W-1){1'b0}}, bad_q});
        chk("check_ready", {a_ready, b_ready}, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_id", done_id, e.id);
          chk("done_ok", done_ok, e.ok);
        end
      end
    end
    corrupt = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; corrupt = 1'b0;
    a_valid = 1'b1; a_dir = 1'b0; a_word = '0;
    b_valid = 1'b1; b_dir = 1'b0; b_word = '0;
    #1;
    chk("reset_outputs", {sr_en, sr_dir, sr_data_in, busy, done, done_id, done_ok}, 0);
    chk("reset_ready", {a_ready, b_ready}, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_no_ready", {a_ready, b_ready}, 0);

    // Contention from reset: A, B, A, B at cycles 0, 7, 14, 21
    a_valid = 1'b1; a_dir = 1'b1; a_word = 5'b01010;
    b_valid = 1'b1; b_dir = 1'b0; b_word = 5'b11001;
    #1;
    run_xfer(1'b0, 1'b1, 5'b01010, 1'b0, 1'b0, 1'b0);
    run_xfer(1'b1, 1'b0, 5'b11001, 1'b0, 1'b0, 1'b0);
    run_xfer(1'b0, 1'b1, 5'b01010, 1'b0, 1'b0, 1'b0);
    run_xfer(1'b1, 1'b0, 5'b11001, 1'b0, 1'b0, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after_contention", {busy, done}, 0);

    // A right shift, B idle
    a_valid = 1'b1; a_dir = 1'b1; a_word = 5'b10110;
    #1;
    run_xfer(1'b0, 1'b1, 5'b10110, 1'b0, 1'b1, 1'b0);

    // Back-to-back A; B raises valid in cycle 2 and waits, then left shift
    a_valid = 1'b1; a_dir = 1'b1; a_word = 5'b11100;
    #1;
    run_xfer(1'b0, 1'b1, 5'b11100, 1'b0, 1'b1, 1'b1);
    run_xfer(1'b1, 1'b0, 5'b10011, 1'b0, 1'b1, 1'b0);

    // Corrupted readback, then a normal request
    a_valid = 1'b1; a_dir = 1'b1; a_word = 5'b01101;
    #1;
    run_xfer(1'b0, 1'b1, 5'b01101, 1'b1, 1'b1, 1'b0);
    b_valid = 1'b1; b_dir = 1'b1; b_word = 5'b00111;
    #1;
    run_xfer(1'b1, 1'b1, 5'b00111, 1'b0, 1'b1, 1'b0);

    // Reset during SHIFT cycle 3
    a_valid = 1'b1; a_dir = 1'b1; a_word = 5'b11001;
    #1;
    chk("rst_pre_ready", a_ready, 1);
    @(negedge clk);
    b_valid = 1'b1; b_dir = 1'b0; b_word = 5'b10101;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_pre_en", sr_en, 1);
    nrst = 1'b0;
    #1;
    chk("rst_async_outputs", {sr_en, sr_dir, sr_data_in, busy, done, done_id, done_ok}, 0);
    chk("rst_async_ready", {a_ready, b_ready}, 0);
    @(negedge clk);
    #1;
    chk("rst_no_done", done, 0);
    nrst = 1'b1;
    #1;
    run_xfer(1'b0, 1'b1, 5'b11001, 1'b0, 1'b1, 1'b0);
    run_xfer(1'b1, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("final_idle", {busy, done, a_ready, b_ready}, 0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
